// File: rtl/sound_cue_sequencer.sv
// Turns one-shot game events into timed note sequences for the buzzer.
// Fixed-priority arbitration with preemption, plus a silent hold after game over.
module sound_cue_sequencer #(
  parameter int NOTE_TICKS = 5000000,
  parameter int GAP_TICKS  = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load_done,
  input  logic       i_perfect,
  input  logic       i_gameover,
  output logic [5:0] music_scale,
  output logic       o_busy,
  output logic [1:0] o_cue
);

  localparam int CW = $clog2(2 * NOTE_TICKS + GAP_TICKS + 1);
  localparam logic [CW-1:0] NOTE_LIM1 = CW'(NOTE_TICKS - 1);
  localparam logic [CW-1:0] NOTE_LIM2 = CW'(2 * NOTE_TICKS - 1);
  localparam logic [CW-1:0] GAP_LIM   = CW'(GAP_TICKS - 1);

  localparam logic [1:0] CUE_NONE = 2'd0;
  localparam logic [1:0] CUE_LAND = 2'd1;
  localparam logic [1:0] CUE_PERF = 2'd2;
  localparam logic [1:0] CUE_GO   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_NOTE, S_GAP, S_HOLD} state_t;

  function automatic logic [5:0] rom_code(input logic [1:0] cue, input logic [1:0] idx);
    case ({cue, idx})
      4'b0100: rom_code = 6'd1;
      4'b0101: rom_code = 6'd3;
      4'b1000: rom_code = 6'd1;
      4'b1001: rom_code = 6'd3;
      4'b1010: rom_code = 6'd5;
      4'b1011: rom_code = 6'd7;
      4'b1100: rom_code = 6'd5;
      4'b1101: rom_code = 6'd3;
      4'b1110: rom_code = 6'd1;
      default: rom_code = 6'd0;
    endcase
  endfunction

  // Notes lasting two duration units; every other note lasts one.
  function automatic logic rom_long(input logic [1:0] cue, input logic [1:0] idx);
    rom_long = (cue == CUE_GO) || (cue == CUE_PERF && idx == 2'd3);
  endfunction

  function automatic logic [1:0] last_idx(input logic [1:0] cue);
    case (cue)
      CUE_LAND: last_idx = 2'd1;
      CUE_PERF: last_idx = 2'd3;
      CUE_GO:   last_idx = 2'd2;
      default:  last_idx = 2'd0;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [1:0]      cue_q, cue_d;
  logic [1:0]      idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [5:0]      scale_q, scale_d;
  logic            ld_prev_q, go_prev_q;

  logic            ld_evt, go_evt, note_end, gap_end, cue_done, accept;
  logic [1:0]      new_cue;

  always_comb begin
    ld_evt   = i_load_done & ~ld_prev_q;
    go_evt   = i_gameover & ~go_prev_q;
    new_cue  = go_evt ? CUE_GO : (ld_evt ? (i_perfect ? CUE_PERF : CUE_LAND) : CUE_NONE);
    note_end = (state_q == S_NOTE) &&
               (cnt_q == (rom_long(cue_q, idx_q) ? NOTE_LIM2 : NOTE_LIM1));
    gap_end  = (state_q == S_GAP) && (cnt_q == GAP_LIM);
    cue_done = gap_end && (idx_q == last_idx(cue_q));
    // A finishing non-gameover cue yields to any event coinciding with its last edge.
    accept   = (new_cue != CUE_NONE) && (state_q != S_HOLD) &&
               ((new_cue >= cue_q) || (cue_done && cue_q != CUE_GO));

    state_d = state_q;
    cue_d   = cue_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    scale_d = scale_q;

    if (accept) begin
      state_d = S_NOTE;
      cue_d   = new_cue;
      idx_d   = 2'd0;
      cnt_d   = '0;
      scale_d = rom_code(new_cue, 2'd0);
    end else begin
      case (state_q)
        S_NOTE: begin
          if (note_end) begin
            state_d = S_GAP;
            cnt_d   = '0;
            scale_d = 6'd0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_GAP: begin
          if (cue_done) begin
            state_d = (cue_q == CUE_GO) ? S_HOLD : S_IDLE;
            cue_d   = (cue_q == CUE_GO) ? CUE_GO : CUE_NONE;
            idx_d   = 2'd0;
            cnt_d   = '0;
          end else if (gap_end) begin
            state_d = S_NOTE;
            idx_d   = idx_q + 2'd1;
            cnt_d   = '0;
            scale_d = rom_code(cue_q, idx_q + 2'd1);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_HOLD: begin
          if (!i_gameover) begin
            state_d = S_IDLE;
            cue_d   = CUE_NONE;
          end
        end
        default: begin
          scale_d = 6'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cue_q     <= CUE_NONE;
      idx_q     <= 2'd0;
      cnt_q     <= '0;
      scale_q   <= 6'd0;
      ld_prev_q <= 1'b1;
      go_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cue_q     <= cue_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      scale_q   <= scale_d;
      ld_prev_q <= i_load_done;
      go_prev_q <= i_gameover;
    end
  end

  assign music_scale = scale_q;
  assign o_busy      = (state_q == S_NOTE) || (state_q == S_GAP);
  assign o_cue       = cue_q;

endmodule

// File: doc/sound_cue_sequencer.md
# sound_cue_sequencer

Event-to-melody controller that sits between the game-logic flags and the `Buzzer` block. It turns one-shot game events (landing, perfect landing, game over) into short timed note sequences on `music_scale`. It arbitrates between overlapping events by fixed priority with preemption, and holds the buzzer silent after a game-over cue until the game-over level drops.

## Interface

Parameters:
- `NOTE_TICKS`, default 5000000: clock cycles per duration unit (50 ms at 100 MHz). Must be ≥1.
- `GAP_TICKS`, default 1000000: silent cycles after every note, so repeated notes re-articulate. Must be ≥1.

Ports:
- `clk`, input, 1: system clock, single clock domain.
- `rst`, input, 1: reset, synchronous, active-high.
- `i_load_done`, input, 1: player landed on a box; rising edge is the event.
- `i_perfect`, input, 1: qualifier sampled on the same edge as the `i_load_done` rising edge.
- `i_gameover`, input, 1: game-over level; rising edge is the event.
- `music_scale`, output, 6: note code to `Buzzer`; 0 means silent. Registered.
- `o_busy`, output, 1: high while a cue is playing (NOTE or GAP state).
- `o_cue`, output, 2: active cue: 0 none, 1 LAND, 2 PERFECT, 3 GAMEOVER.

## Operation

- **Edge detect:** previous-value registers for `i_load_done` and `i_gameover`. An event fires on the edge where the input is 1 and its registered previous value is 0. Reset sets both previous registers to 1, so levels held high through reset do not trigger.
- **Cue decode** (internal ROM of note code and duration units):
  - `i_load_done`↑ with `i_perfect`=0 → LAND: (1,1) (3,1).
  - `i_load_done`↑ with `i_perfect`=1 → PERFECT: (1,1) (3,1) (5,1) (7,2).
  - `i_gameover`↑ → GAMEOVER: (5,2) (3,2) (1,2).
- **Priority:** GAMEOVER > PERFECT > LAND.
  - Both events on the same edge: GAMEOVER wins and the other is dropped.
  - New event with priority ≥ active cue: abort the active cue and restart at note 0 of the new cue on that edge.
  - New event with priority lower than active cue: dropped; no pending queue.
- **States:** IDLE, NOTE, GAP, HOLD.
  - IDLE: `music_scale`=0, `o_cue`=0. On event → NOTE, index 0.
  - NOTE: `music_scale`=ROM code. Stays for dur×NOTE_TICKS cycles, then → GAP.
  - GAP: `music_scale`=0 for GAP_TICKS cycles. Then → NOTE at index+1 if more notes remain. Otherwise → HOLD if cue is GAMEOVER, else → IDLE.
  - HOLD: `music_scale`=0, `o_busy`=0, `o_cue`=3. LAND and PERFECT events are ignored. When `i_gameover` is sampled 0 → IDLE. A new `i_gameover`↑ can only occur after HOLD has exited.
- **Counters:**
  - Tick counter width is `$clog2(2*NOTE_TICKS+GAP_TICKS+1)`. It counts from 0 and the terminal condition is count == limit−1. No wrap-around is possible.
  - Note index is 2 bits; 4 notes maximum.

## Timing

- **Reset values:** `music_scale`=0, `o_busy`=0, `o_cue`=0, state IDLE, all counters 0.
- **Reset mid-cue:** all outputs at their reset values after the reset edge; the cue is lost.
- **Event latency:** `music_scale`, `o_busy` and `o_cue` take the first note values at the same clock edge that samples the rising input.
- **Note length:** each note is exactly dur×NOTE_TICKS cycles, followed by exactly GAP_TICKS cycles of 0.
- **Cue end:** `o_busy` falls on the edge that ends the last gap. The next cue may start on that same edge if its event coincides.
- **Preemption:** the new cue's first note appears on the triggering edge, with no extra gap inserted. The tick counter restarts from 0.
- **Static inputs:** `i_perfect` is irrelevant except on a `i_load_done` rising edge.

## Test plan

All scenarios use `NOTE_TICKS`=4, `GAP_TICKS`=2.

- **Reset:** hold `rst` 3 cycles with `i_gameover`=1, then release → `music_scale`=0 and `o_cue`=0 throughout, no cue starts.
- **LAND:** `i_load_done` 1-cycle pulse, `i_perfect`=0 → `music_scale` sequence 1×4, 0×2, 3×4, 0×2; `o_busy` high exactly 12 cycles; `o_cue`=1.
- **PERFECT:** pulse with `i_perfect`=1 → 1×4, 0×2, 3×4, 0×2, 5×4, 0×2, 7×8, 0×2; 28 busy cycles; `o_cue`=2.
- **Preempt:** start PERFECT, raise `i_gameover` on cycle 7 → `music_scale`=5 on that edge, then the GAMEOVER sequence 5×8, 0×2, 3×8, 0×2, 1×8, 0×2. Then HOLD with `o_cue`=3 and `o_busy`=0. A `i_load_done` pulse during HOLD gives no sound. Lower `i_gameover` → IDLE the next edge.
- **Drop and simultaneity:**
  - `i_load_done` pulse during GAMEOVER → sequence unchanged.
  - `i_load_done` and `i_gameover` rising on the same edge → GAMEOVER only.
- **Retrigger and mid-cue reset:**
  - Second LAND pulse at cycle 5 of a LAND cue → the cue restarts: `music_scale`=1 for 4 cycles from that edge.
  - `rst` pulse mid-cue → `music_scale`=0 and IDLE on the next edge.
